uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 65 ++++++
 rtl/uart_rx_fsm.sv | 127 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared definitions for the UART receiver.
//   rx_state_e        : receiver FSM state encoding
//   DATA_BITS         : data bits per frame
//   PRESCALE_8/16/32  : the legal oversampling ratios
//   prescale_legal()  : true for a legal oversampling ratio
//   majority3()       : 2-of-3 vote used for bit sampling
package uart_rx_pkg;

  localparam int DATA_BITS   = 8;
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic prescale_legal(input logic [31:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// edge_bit_counter -- per-bit oversampling counter and 3-sample majority voter.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : start detected; capture prescale_i and clear the counter
//   run_i           : a frame is in progress; count edges and sample
//   rx_i            : serial line
//   prescale_i      : oversampling ratio (captured only on start_i)
//   bit_end_o       : counter is at the last edge (P-1) of the current bit
//   sampled_bit_o   : majority of the samples at edges P/2-1, P/2, P/2+1
//   valid_o         : one-cycle strobe at edge P/2+2, sampled_bit_o is fresh
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  run_i,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_end_o,
  output logic                  sampled_bit_o,
  output logic                  valid_o
);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] half;
  logic                  s0_q, s1_q, bit_q, valid_q;

  assign half      = presc_q >> 1;
  assign bit_end_o = (cnt_q == presc_q - 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= PRESCALE_W'(PRESCALE_8);
      cnt_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_i) begin
        // An illegal ratio falls back to 8 so the counter always wraps sanely.
        presc_q <= prescale_legal(32'(prescale_i)) ? prescale_i
                                                   : PRESCALE_W'(PRESCALE_8);
        cnt_q   <= '0;
      end else if (run_i) begin
        cnt_q <= bit_end_o ? '0 : cnt_q + 1'b1;
        if (cnt_q == half - 1'b1) s0_q <= rx_i;
        if (cnt_q == half)        s1_q <= rx_i;
        if (cnt_q == half + 1'b1) begin
          bit_q   <= majority3(s0_q, s1_q, rx_i);
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign sampled_bit_o = bit_q;
  assign valid_o       = valid_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- UART receiver: start/data/parity/stop FSM and deserializer.
// Optional feature: define UART_RX_SYNC_EN to pass RX_IN through a 2-flop
// synchronizer (reset value 1) first; this adds 2 cycles to every latency.
// Ports:
//   CLK          : oversampling clock
//   RST          : asynchronous active-low reset
//   RX_IN        : serial line, idle high
//   Prescale     : oversampling ratio (8, 16 or 32), captured at start detect
//   PAR_EN       : frame carries a parity bit
//   par_err      : registered verdict of the external parity checker
//   sampled_bit  : majority-voted bit value
//   valid        : one-cycle strobe, sampled_bit is valid
//   par_chk_en   : high throughout the PARITY state
//   data         : deserializer shift register (to the parity checker)
//   P_DATA       : last good byte, held until the next good frame
//   data_valid   : one-cycle pulse, good frame delivered
//   stp_err      : one-cycle pulse, stop bit sampled 0
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic                  valid,
  output logic                  par_chk_en,
  output logic [7:0]            data,
  output logic [7:0]            P_DATA,
  output logic                  data_valid,
  output logic                  stp_err
);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] data_q, p_data_q;
  logic       par_chk_en_q, data_valid_q, stp_err_q;
  logic       bit_end, smp_bit, smp_valid, start_det, running;

  assign running = (state_q != IDLE);
  // Covers both IDLE->START and the back-to-back STOP->START path.
  assign start_det = (state_d == START) && (state_q != START);

  edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .clk_i         (CLK),
    .rst_ni        (RST),
    .start_i       (start_det),
    .run_i         (running),
    .rx_i          (rx_s),
    .prescale_i    (Prescale),
    .bit_end_o     (bit_end),
    .sampled_bit_o (smp_bit),
    .valid_o       (smp_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START: begin
        // A start bit that votes high is a glitch: drop back to IDLE.
        if (smp_valid && smp_bit) state_d = IDLE;
        else if (bit_end)         state_d = DATA;
      end
      DATA:   if (bit_end && (bit_cnt_q == 3'(DATA_BITS - 1)))
                state_d = PAR_EN ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = rx_s ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      p_data_q     <= '0;
      par_chk_en_q <= 1'b0;
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_chk_en_q <= (state_d == PARITY);
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
      if (start_det)                   bit_cnt_q <= '0;
      else if (state_q == DATA && bit_end) bit_cnt_q <= bit_cnt_q + 1'b1;
      // Right shift: the LSB, sent first, ends up in data[0].
      if (state_q == DATA && smp_valid) data_q <= {smp_bit, data_q[7:1]};
      if (state_q == STOP && bit_end) begin
        if (!smp_bit) begin
          stp_err_q <= 1'b1;
        end else if (!PAR_EN || !par_err) begin
          data_valid_q <= 1'b1;
          p_data_q     <= data_q;
        end
      end
    end
  end

  assign sampled_bit = smp_bit;
  assign valid       = smp_valid;
  assign par_chk_en  = par_chk_en_q;
  assign data        = data_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = data_valid_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       par_err = 1'b0;
  logic       sampled_bit, valid, par_chk_en, data_valid, stp_err;
  logic [7:0] data, P_DATA;

  uart_rx_fsm #(.PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .par_err     (par_err),
    .sampled_bit (sampled_bit),
    .valid       (valid),
    .par_chk_en  (par_chk_en),
    .data        (data),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .stp_err     (stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] pdata;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_pdata = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         vcnt = 0;
  int         pccnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every delivered frame or stop error is matched against the scoreboard.
  always @(negedge CLK) begin
    if (valid)      vcnt  <= vcnt + 1;
    if (par_chk_en) pccnt <= pccnt + 1;
    if (RST && (data_valid || stp_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, data_valid, stp_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {30'd0, data_valid, stp_err},
            mon_e.is_err ? 32'd1 : 32'd2);
        chk("P_DATA_at_pulse", 32'(P_DATA), 32'(mon_e.pdata));
        chk("latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame starting at a negedge; pushes what the receiver must report.
  task automatic send_frame(input int p, input logic [7:0] b, input bit pen,
                            input bit bad_par, input bit stop);
    exp_t e;
    int   t0;
    RX_IN    = 1'b0;
    Prescale = 6'(p);
    t0       = cyc + 1;
    e.due    = t0 + (pen ? 11 : 10) * p + SYNC_LAT;
    if (!stop) begin
      e.is_err = 1'b1;
      e.pdata  = model_pdata;
      sb.push_back(e);
    end else if (!(pen && bad_par)) begin
      e.is_err    = 1'b0;
      e.pdata     = b;
      model_pdata = b;
      sb.push_back(e);
    end
    repeat (4) @(negedge CLK);
    // Frame options change only after the previous frame has been decided;
    // Prescale is scrambled mid-frame and must be ignored.
    PAR_EN   = pen;
    par_err  = pen & bad_par;
    Prescale = 6'(8 << $urandom_range(0, 2));
    repeat (p - 4) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = b[i];
      repeat (p) @(negedge CLK);
    end
    if (pen) begin
      RX_IN = (^b) ^ bad_par;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop;
    repeat (p) @(negedge CLK);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int v0, pc0, p, gap;
    logic [7:0] b;
    bit pen, bad, stop;

    repeat (3) @(negedge CLK);
    chk("rst_P_DATA", 32'(P_DATA), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sampled_bit", 32'(sampled_bit), 32'd0);
    chk("rst_par_chk_en", 32'(par_chk_en), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_stp_err", 32'(stp_err), 32'd0);
    RST = 1'b1;
    idle(5);

    // P=8, no parity, 0xA5: latency 80.
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("a5_P_DATA", 32'(P_DATA), 32'hA5);
    chk("a5_data", 32'(data), 32'hA5);

    // P=16 with good parity: latency 176, PARITY lasts one bit time.
    pc0 = pccnt;
    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1);
    idle(20);
    chk("3c_P_DATA", 32'(P_DATA), 32'h3C);
    chk("3c_par_chk_en_cycles", 32'(pccnt - pc0), 32'd16);

    // Parity failure: nothing delivered, P_DATA retained.
    send_frame(16, 8'h96, 1'b1, 1'b1, 1'b1);
    idle(40);
    chk("parfail_P_DATA", 32'(P_DATA), 32'h3C);
    drain("parfail_drain");

    // 3-cycle glitch: one valid strobe, false start.
    v0 = vcnt;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    idle(40);
    chk("glitch_valid_count", 32'(vcnt - v0), 32'd1);
    chk("glitch_sampled_bit", 32'(sampled_bit), 32'd1);

    // P=32 bad stop bit, then 0x55 back-to-back.
    send_frame(32, 8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(32, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(40);
    chk("b2b_P_DATA", 32'(P_DATA), 32'h55);
    drain("b2b_drain");

    // Reset in the middle of the DATA bits of 0xFF.
    RX_IN = 1'b0;
    Prescale = 6'd16;
    repeat (16) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (16 * 3 + 10) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_sampled_bit", 32'(sampled_bit), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_par_chk_en", 32'(par_chk_en), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_P_DATA", 32'(P_DATA), 32'd0);
    chk("midrst_data_valid", 32'(data_valid), 32'd0);
    chk("midrst_stp_err", 32'(stp_err), 32'd0);
    model_pdata = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(300);
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("after_rst_P_DATA", 32'(P_DATA), 32'h81);

    // Randomized frames, gaps and back-to-back traffic.
    for (int k = 0; k < 30; k++) begin
      p    = 8 << $urandom_range(0, 2);
      b    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      bad  = pen && ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      send_frame(p, b, pen, bad, stop);
      if (gap != 0) idle(gap);
    end
    idle(400);
    drain("final_drain");
    chk("final_P_DATA", 32'(P_DATA), 32'(model_pdata));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
